fifo_reader: RTL
================

Name: fifo_reader

Overview:
- Read-side client of the team's 8-deep, 32-bit FIFO.
- Issues read requests on the FIFO's rd_en/rd_ack/rd_err handshake and captures the registered read data into a small local buffer.
- Re-presents the words downstream on a valid/ready stream.
- Sits between the FIFO and any consumer that can stall, and sustains one word per cycle when the consumer is always ready.

Parameters:
- DATA_W, 32, data word width; must match the FIFO data width.
- BUF_DEPTH, 3, local buffer entries; minimum 2; 3 is required for full throughput.
- ERR_W, 8, width of the saturating read-error counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  permission to issue new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_ack  in  1  FIFO read acknowledge; valid the cycle after rd_en.
- fifo_rd_err  in  1  FIFO read error (read of empty FIFO); valid the cycle after rd_en.
- fifo_d_out  in  DATA_W  FIFO registered read data; valid only when fifo_rd_ack=1.
- fifo_rd_en  out  1  read request to the FIFO.
- m_data  out  DATA_W  downstream data.
- m_valid  out  1  downstream data valid.
- m_ready  in  1  downstream accept.
- rd_count  out  16  words acknowledged since reset; wraps at 2^16.
- err_count  out  ERR_W  rd_err events since reset; saturates at all-ones.
- proto_err  out  1  sticky protocol-violation flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-high. Every output and every state element goes to 0 immediately: buffer occupancy, pointers, inflight, counters, proto_err, and state=IDLE. fifo_rd_en and m_valid are 0 during reset.
- FIFO timing contract:
  - rd_en sampled at edge N produces rd_ack=1 with data on fifo_d_out, or rd_err=1, during cycle N+1.
  - fifo_d_out is don't-care otherwise.
- inflight register:
  - Set to 1 at any edge where fifo_rd_en=1, else 0.
  - It therefore marks exactly the cycle in which a response is due.
- Request rule, combinational from registers and inputs only:
  - fifo_rd_en = en & ~fifo_empty & (occ + inflight < BUF_DEPTH).
  - There is no combinational path from m_ready to fifo_rd_en.
  - Back-to-back requests are allowed every cycle.
- Response handling in a cycle with inflight=1:
  - rd_ack=1: push fifo_d_out into the buffer; rd_count+1.
  - rd_err=1: no push; err_count+1, saturating.
  - Both ack and err, or neither: proto_err is set. On both, the data is still pushed.
- Response handling with inflight=0:
  - Any rd_ack or rd_err sets proto_err.
  - Data is discarded and counters are unchanged.
- Buffer:
  - Circular, BUF_DEPTH entries, with occupancy occ (0..BUF_DEPTH).
  - m_valid = (occ != 0); m_data = entry at the read pointer, driven from a register.
  - Pop happens on m_valid & m_ready.
  - Push and pop in the same cycle leave occ unchanged, and the pushed word goes behind the popped one.
  - Pointers wrap modulo BUF_DEPTH.
  - Overflow cannot occur by the request rule. If it ever would, set proto_err and drop the word.
- Stall: while m_valid=1 and m_ready=0, m_data and m_valid must remain stable.
- FSM states:
  - IDLE: en=0, occ=0, inflight=0.
  - RUN: en=1.
  - DRAIN: en=0 and (occ!=0 or inflight=1).
- FSM transitions:
  - IDLE→RUN when en=1.
  - RUN→DRAIN when en=0 and the block is not empty.
  - RUN→IDLE when en=0 and the block is empty.
  - DRAIN→RUN when en=1.
  - DRAIN→IDLE once occ=0 and inflight=0.
  - No requests are issued in DRAIN or IDLE. An in-flight response is still accepted in DRAIN.
- Boundaries:
  - fifo_empty=1 suppresses requests in the same cycle.
  - err_count holds at 2^ERR_W-1.
  - rd_count wraps from 0xFFFF to 0.
- Reset mid-operation: buffered words are lost; the FIFO shares the reset.

Decomposition:
- Package fifo_reader_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - the rd_count width constant 16;
  - the default widths.
- One sub-module, fifo_reader_buf:
  - the circular buffer with occ and pointers;
  - push/pop inputs, m_data/m_valid outputs, and an overflow pulse.
- The top holds the FSM, inflight, request logic, counters and proto_err.

Test Plan:
1. FIFO model preloaded with 0xA0..0xA7, en=1, m_ready=1 → fifo_rd_en asserts for 8 consecutive cycles. m_data shows 0xA0..0xA7 on 8 consecutive cycles starting 2 cycles after the first request. rd_count=8, err_count=0, proto_err=0.
2. Same data, m_ready=0 for 10 cycles, then 1 → at most 3 requests are issued. m_data is held at 0xA0 throughout the stall. The full sequence is delivered in order with nothing lost or duplicated.
3. Model returns rd_err=1 to a request when fifo_empty is forced 0 on an empty FIFO → no word is pushed, m_valid stays 0, err_count=1. After 300 such errors, err_count=255.
4. rd_ack pulsed with no outstanding request → proto_err=1 and stays 1; rd_count is unchanged.
5. en dropped the cycle after a request, with 2 words buffered → busy remains 1 in DRAIN. The third word arrives and all 3 are delivered; then busy=0. No further rd_en.
6. reset asserted asynchronously mid-burst (occ=2, inflight=1) → all outputs are 0 immediately, without waiting for a clock edge. After release, state=IDLE and rd_count=0.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding and default widths for the FIFO read client
package fifo_reader_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int RD_CNT_W      = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BUF_DEPTH = 3;
    localparam int DEF_ERR_W     = 8;
endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: circular skid buffer presenting registered words on a valid/ready stream
module fifo_reader_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic [OCC_W-1:0]  occ,
    output logic              overflow
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              pop, full, wr_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_valid  = occ_q != '0;
    assign m_data   = mem_q[rd_q];
    assign occ      = occ_q;
    assign pop      = m_valid & pop_ready;
    assign full     = occ_q == OCC_W'(DEPTH);
    assign wr_ok    = push & (~full | pop);
    assign overflow = push & full & ~pop;

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[wr_q] = push_data;
        wr_d  = wr_ok ? inc(wr_q) : wr_q;
        rd_d  = pop ? inc(rd_q) : rd_q;
        occ_d = occ_q + OCC_W'(wr_ok) - OCC_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: issues FIFO reads, buffers the responses and streams them downstream
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int ERR_W     = DEF_ERR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic                fifo_rd_ack,
    input  logic                fifo_rd_err,
    input  logic [DATA_W-1:0]   fifo_d_out,
    output logic                fifo_rd_en,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RD_CNT_W-1:0] rd_count,
    output logic [ERR_W-1:0]    err_count,
    output logic                proto_err,
    output logic                busy
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    state_t               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic [RD_CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic                 proto_err_q, proto_err_d;
    logic [OCC_W-1:0]     occ;
    logic                 push, overflow, blk_empty;

    fifo_reader_buf #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_d_out),
        .pop_ready (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .occ       (occ),
        .overflow  (overflow)
    );

    // Space is reserved for the in-flight response so the buffer can never overflow.
    assign fifo_rd_en = ~reset & en & ~fifo_empty & ((int'(occ) + int'(inflight_q)) < BUF_DEPTH);
    assign push       = inflight_q & fifo_rd_ack;
    assign blk_empty  = (occ == '0) & ~inflight_q;
    assign rd_count   = rd_count_q;
    assign err_count  = err_count_q;
    assign proto_err  = proto_err_q;

    always_comb begin
        inflight_d  = fifo_rd_en;
        rd_count_d  = rd_count_q + RD_CNT_W'(push);
        err_count_d = (inflight_q & fifo_rd_err & ~&err_count_q) ? err_count_q + ERR_W'(1) : err_count_q;
        proto_err_d = proto_err_q | overflow |
                      (inflight_q ? (fifo_rd_ack == fifo_rd_err) : (fifo_rd_ack | fifo_rd_err));
    end

    always_comb begin
        state_d = en ? RUN : (blk_empty ? IDLE : DRAIN);
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            inflight_q  <= 1'b0;
            rd_count_q  <= '0;
            err_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule
